// File: rtl/mux_bin_pkg.sv
// Shared arbitration helpers: index-width function and round-robin grant search.
// Pure combinational functions with no latency and no backpressure of their own.
package mux_bin_pkg;

    // rr_next searches at most this many requesters.
    localparam int RR_MAX = 64;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // First set bit of req[0 +: width] at or after ptr, wrapping at width.
    // Returns the grant valid; idx is the granted index (0 when nothing is set).
    function automatic logic rr_next(
        input  logic [RR_MAX-1:0] req,
        input  int unsigned       ptr,
        input  int unsigned       width,
        output int unsigned       idx
    );
        logic        found;
        int unsigned j;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            if (i < width) begin
                j = ptr + i;
                if (j >= width) j = j - width;
                if (!found && req[j]) begin
                    found = 1'b1;
                    idx   = j;
                end
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/mux_bin.sv
// Binary-select multiplexer: flat (IMPLEMENTATION=0) or two-level radix-SPLIT tree.
// Purely combinational, zero latency; no flow control. Select codes >= WIDTH yield '0.
module mux_bin
    import mux_bin_pkg::*;
#(
    parameter type DAT_T          = logic [8-1:0],
    parameter int  WIDTH          = 4,
    parameter int  SPLIT          = 2,
    parameter int  IMPLEMENTATION = 0,
    localparam int SEL_W          = idx_width(WIDTH)
)(
    input  logic [SEL_W-1:0]   sel,
    input  DAT_T [WIDTH-1:0]   in_dat,
    output DAT_T               out_dat
);

    int sel_i;
    assign sel_i = 32'(sel);

    if (IMPLEMENTATION == 0) begin : g_flat
        always_comb begin
            out_dat = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (sel_i == i) out_dat = in_dat[i];
            end
        end
    end else begin : g_tree
        localparam int NGRP = (WIDTH + SPLIT - 1) / SPLIT;
        DAT_T grp_dat [NGRP];

        // First level picks within each group on the low select digit,
        // second level picks the group on the high digit.
        always_comb begin
            for (int g = 0; g < NGRP; g++) grp_dat[g] = '0;
            out_dat = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if ((sel_i % SPLIT) == (i % SPLIT)) grp_dat[i / SPLIT] = in_dat[i];
            end
            for (int g = 0; g < NGRP; g++) begin
                if ((sel_i / SPLIT) == g) out_dat = grp_dat[g];
            end
        end
    end

endmodule

// File: rtl/mux_bin_arb.sv
// Round-robin arbiter feeding a shared mux_bin into one registered output stage.
// Latency 1 cycle grant-to-out_vld; full throughput while out_rdy=1.
// Backpressure: req_rdy is held at zero while the output beat is stalled. Packet lock via MUX_BIN_ARB_LOCK_EN.
module mux_bin_arb
    import mux_bin_pkg::*;
#(
    parameter type DAT_T          = logic [8-1:0],
    parameter int  WIDTH          = 4,
    parameter int  SPLIT          = 2,
    parameter int  IMPLEMENTATION = 0,
    localparam int WIDTH_LOG      = idx_width(WIDTH)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     req_vld,
    output logic [WIDTH-1:0]     req_rdy,
    input  DAT_T [WIDTH-1:0]     req_dat,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output DAT_T                 out_dat,
    output logic [WIDTH_LOG-1:0] out_idx
`ifdef MUX_BIN_ARB_LOCK_EN
    ,
    input  logic [WIDTH-1:0]     req_lst,
    output logic                 out_lst
`endif
);

    logic [WIDTH_LOG-1:0] ptr;
    logic [WIDTH_LOG-1:0] ptr_nxt;
    logic [WIDTH-1:0]     elig;
    logic [WIDTH_LOG-1:0] gnt_idx;
    logic                 gnt_vld;
    logic                 ld;
    logic                 xfer;
    logic                 last_beat;
    DAT_T                 mux_dat;

`ifdef MUX_BIN_ARB_LOCK_EN
    logic lock;
`endif

    assign ld   = !out_vld || out_rdy;
    assign xfer = ld && gnt_vld;

    always_comb begin
        int unsigned gnt_raw;
        gnt_raw = 0;
        elig    = req_vld;
`ifdef MUX_BIN_ARB_LOCK_EN
        // While mid-packet only the owner (still held in out_idx) may win.
        if (lock) elig = req_vld & (WIDTH'(1) << out_idx);
`endif
        gnt_vld = rr_next(RR_MAX'(elig), 32'(ptr), WIDTH, gnt_raw);
        gnt_idx = WIDTH_LOG'(gnt_raw);
    end

    assign ptr_nxt = (gnt_idx == WIDTH_LOG'(WIDTH - 1)) ? '0 : gnt_idx + WIDTH_LOG'(1);
    assign req_rdy = (xfer && !rst) ? (WIDTH'(1) << gnt_idx) : '0;

`ifdef MUX_BIN_ARB_LOCK_EN
    assign last_beat = req_lst[gnt_idx];
`else
    assign last_beat = 1'b1;
`endif

    mux_bin #(
        .DAT_T          (DAT_T),
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_mux (
        .sel     (gnt_idx),
        .in_dat  (req_dat),
        .out_dat (mux_dat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_idx <= '0;
            out_dat <= '0;
            ptr     <= '0;
        end else if (ld) begin
            out_vld <= gnt_vld;
            if (gnt_vld) begin
                out_dat <= mux_dat;
                out_idx <= gnt_idx;
                if (last_beat) ptr <= ptr_nxt;
            end
        end
    end

`ifdef MUX_BIN_ARB_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock    <= 1'b0;
            out_lst <= 1'b0;
        end else if (xfer) begin
            lock    <= !last_beat;
            out_lst <= last_beat;
        end
    end
`endif

endmodule

// File: tb/tb_mux_bin_arb.sv
// Bench for mux_bin_arb: directed vector table, hand sequences, and randomized run vs. a queue-free reference.
module tb_mux_bin_arb;

`ifdef MUX_BIN_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk, rst;
    logic [3:0]      a_vld, a_rdy, a_lst;
    logic [3:0][7:0] a_dat;
    logic            a_ovld, a_ordy;
    logic [7:0]      a_odat;
    logic [1:0]      a_oidx;
    logic [4:0]      b_vld, b_rdy, b_lst;
    logic [4:0][7:0] b_dat;
    logic            b_ovld, b_ordy;
    logic [7:0]      b_odat;
    logic [2:0]      b_oidx;
`ifdef MUX_BIN_ARB_LOCK_EN
    logic            a_olst, b_olst;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference state per DUT (0 = WIDTH 4, 1 = WIDTH 5)
    int         m_ptr  [2];
    int         m_idx  [2];
    bit         m_vld  [2];
    bit         m_lock [2];
    bit         m_lst  [2];
    logic [7:0] m_dat  [2];

    mux_bin_arb #(.DAT_T(logic [7:0]), .WIDTH(4), .SPLIT(2), .IMPLEMENTATION(0)) u_a (
        .clk(clk), .rst(rst), .req_vld(a_vld), .req_rdy(a_rdy), .req_dat(a_dat),
        .out_vld(a_ovld), .out_rdy(a_ordy), .out_dat(a_odat), .out_idx(a_oidx)
`ifdef MUX_BIN_ARB_LOCK_EN
        , .req_lst(a_lst), .out_lst(a_olst)
`endif
    );

    mux_bin_arb #(.DAT_T(logic [7:0]), .WIDTH(5), .SPLIT(2), .IMPLEMENTATION(1)) u_b (
        .clk(clk), .rst(rst), .req_vld(b_vld), .req_rdy(b_rdy), .req_dat(b_dat),
        .out_vld(b_ovld), .out_rdy(b_ordy), .out_dat(b_odat), .out_idx(b_oidx)
`ifdef MUX_BIN_ARB_LOCK_EN
        , .req_lst(b_lst), .out_lst(b_olst)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic mreset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_idx[d] = 0; m_vld[d] = 0;
            m_lock[d] = 0; m_lst[d] = 0; m_dat[d] = 8'h00;
        end
    endtask

    // One clock edge of the reference: returns the ready vector expected before the edge.
    task automatic mstep(input int d, input int w, input logic [4:0] vld, input logic [4:0] lst,
                         input logic ordy, input logic [4:0][7:0] dat, output logic [4:0] exp_rdy);
        int g;
        bit last;
        exp_rdy = '0;
        if (!m_vld[d] || ordy) begin
            g = -1;
            for (int k = 0; k < w; k++) begin
                int j;
                j = (m_ptr[d] + k) % w;
                if (g < 0 && vld[j] && (!m_lock[d] || j == m_idx[d])) g = j;
            end
            m_vld[d] = (g >= 0);
            if (g >= 0) begin
                exp_rdy[g] = 1'b1;
                last       = !LOCK_EN || lst[g];
                m_dat[d]   = dat[g];
                m_idx[d]   = g;
                m_lst[d]   = last;
                m_lock[d]  = !last;
                if (last) m_ptr[d] = (g + 1) % w;
            end
        end
    endtask

    task automatic rand_cycle(input int n);
        logic [4:0] ea, eb;
        a_vld  = 4'($urandom_range(0, 15));
        b_vld  = 5'($urandom_range(0, 31));
        a_ordy = ($urandom_range(0, 3) != 0);
        b_ordy = ($urandom_range(0, 3) != 0);
        a_dat  = $urandom;
        b_dat  = {8'($urandom), 32'($urandom)};
        a_lst  = 4'($urandom);
        b_lst  = 5'($urandom);
        #1;
        mstep(0, 4, {1'b0, a_vld}, {1'b0, a_lst}, a_ordy, {8'h00, a_dat}, ea);
        mstep(1, 5, b_vld, b_lst, b_ordy, b_dat, eb);
        chk($sformatf("rnd%0d_a_req_rdy", n), a_rdy, ea[3:0]);
        chk($sformatf("rnd%0d_b_req_rdy", n), b_rdy, eb);
        tick();
        chk($sformatf("rnd%0d_a_out_vld", n), a_ovld, m_vld[0]);
        chk($sformatf("rnd%0d_a_out_idx", n), a_oidx, m_idx[0]);
        chk($sformatf("rnd%0d_a_out_dat", n), a_odat, m_dat[0]);
        chk($sformatf("rnd%0d_b_out_vld", n), b_ovld, m_vld[1]);
        chk($sformatf("rnd%0d_b_out_idx", n), b_oidx, m_idx[1]);
        chk($sformatf("rnd%0d_b_out_dat", n), b_odat, m_dat[1]);
`ifdef MUX_BIN_ARB_LOCK_EN
        chk($sformatf("rnd%0d_a_out_lst", n), a_olst, m_lst[0]);
        chk($sformatf("rnd%0d_b_out_lst", n), b_olst, m_lst[1]);
`endif
    endtask

    typedef struct {
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_ovld;
        logic [1:0] exp_idx;
    } vec_t;

    vec_t tbl [20];

    initial begin
        tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[4]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[8]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[10] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[11] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[12] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[13] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2};
        tbl[15] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[16] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[17] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[18] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3};
        tbl[19] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3};

        rst    = 1'b1;
        a_vld  = 4'b1111; a_ordy = 1'b1; a_lst = 4'b1111;
        b_vld  = 5'b11111; b_ordy = 1'b1; b_lst = 5'b11111;
        a_dat  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        b_dat  = {8'hB4, 8'hB3, 8'hB2, 8'hB1, 8'hB0};
        #1;
        chk("rst_a_req_rdy", a_rdy, 0);
        chk("rst_b_req_rdy", b_rdy, 0);
        tick();
        tick();
        chk("rst_a_out_vld", a_ovld, 0);
        chk("rst_a_out_idx", a_oidx, 0);
        chk("rst_a_out_dat", a_odat, 0);
        chk("rst_b_out_vld", b_ovld, 0);
        a_vld = 4'b0000;
        b_vld = 5'b00000;
        rst   = 1'b0;

        // Directed table on the 4-requester instance
        for (int i = 0; i < 20; i++) begin
            a_vld  = tbl[i].vld;
            a_ordy = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_req_rdy", i), a_rdy, tbl[i].exp_rdy);
            tick();
            chk($sformatf("tbl%0d_out_vld", i), a_ovld, tbl[i].exp_ovld);
            chk($sformatf("tbl%0d_out_idx", i), a_oidx, tbl[i].exp_idx);
            if (tbl[i].exp_ovld) chk($sformatf("tbl%0d_out_dat", i), a_odat, 8'hA0 + tbl[i].exp_idx);
        end

        // Non-power-of-2 width: only ends of the range requesting
        b_vld = 5'b10001;
        for (int k = 0; k < 6; k++) begin
            int e;
            e = (k % 2 == 0) ? 0 : 4;
            #1;
            chk($sformatf("w5_%0d_req_rdy", k), b_rdy, 5'b00001 << e);
            tick();
            chk($sformatf("w5_%0d_out_idx", k), b_oidx, e);
            chk($sformatf("w5_%0d_idx_range", k), (b_oidx <= 3'd4), 1);
            chk($sformatf("w5_%0d_out_dat", k), b_odat, 8'hB0 + 8'(e));
        end
        b_vld = 5'b00000;
        tick();

        // Asynchronous reset with a beat pending
        a_vld  = 4'b0110;
        a_ordy = 1'b0;
        tick();
        chk("arst_pre_vld", a_ovld, 1);
        chk("arst_pre_idx", a_oidx, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_out_vld", a_ovld, 0);
        chk("arst_req_rdy", a_rdy, 0);
        a_vld  = 4'b1111;
        a_ordy = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("arst_post_req_rdy", a_rdy, 4'b0001);
        tick();
        chk("arst_post_vld", a_ovld, 1);
        chk("arst_post_idx", a_oidx, 0);

`ifdef MUX_BIN_ARB_LOCK_EN
        // Three-beat packet from requester 1 while requester 2 waits
        a_vld = 4'b0110;
        a_lst = 4'b0100;
        tick();
        chk("lock_b0_idx", a_oidx, 1);
        chk("lock_b0_lst", a_olst, 0);
        tick();
        chk("lock_b1_idx", a_oidx, 1);
        chk("lock_b1_lst", a_olst, 0);
        a_lst = 4'b0110;
        tick();
        chk("lock_b2_idx", a_oidx, 1);
        chk("lock_b2_lst", a_olst, 1);
        a_vld = 4'b0100;
        tick();
        chk("lock_b3_idx", a_oidx, 2);
        chk("lock_b3_lst", a_olst, 1);
`endif
        a_vld = 4'b0000;
        tick();

        // Randomized run against the reference
        rst = 1'b1;
        #2;
        rst = 1'b0;
        mreset();
        for (int n = 0; n < 600; n++) rand_cycle(n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
